collision_scheduler: RTL and testbench
======================================

# collision_scheduler

Sequences pairwise sprite/object collision tests through a single shared AABB comparator (`aabb_collision`) once per frame. On `start`, typically at vblank, it walks every unordered object pair (i<j) and reads bounding boxes from the object attribute RAM through a 1-cycle-latency read port. For each overlapping pair it emits a handshaked event and accumulates a per-object hit mask. Game logic reads the mask, or the event stream, before the next frame.

## Interface
- `NUM_OBJ`, 8: number of objects scanned, ≥2.
- `POSITION_REG_MAX`, 11: MSB index of one coordinate; coordinate width is `POSITION_REG_MAX+1`.
- `IDX_W`, `$clog2(NUM_OBJ)`: object index width (localparam).
- `BOX_W`, `4*(POSITION_REG_MAX+1)`: packed box width (localparam).

- `clk` in 1: sole clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: pulse; begins a scan when idle.
- `obj_enable` in NUM_OBJ: per-object enable, captured on accepted `start`.
- `rd_addr` out IDX_W: object RAM read address.
- `rd_data` in BOX_W: box at the address of the previous cycle. Packing: {y2, x2, y1, x1}, with x1 at the LSBs.
- `hit_valid` out 1: overlapping pair presented.
- `hit_a`, `hit_b` out IDX_W: pair indices, always hit_a < hit_b.
- `hit_ready` in 1: consumer accepts the pair.
- `hit_mask` out NUM_OBJ: bit k set if object k hit anything this scan.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse at scan end.

## Operation
- FSM states: IDLE, RD_A, RD_B, CMP, EMIT, DONE. Counters i and j are IDX_W bits wide.
- IDLE: on `start`, set i=0, j=1, clear `hit_mask`, latch `obj_enable`, go to RD_A. A `start` outside IDLE is ignored.
- RD_A: `rd_addr`=i; go to RD_B.
- RD_B: `rd_addr`=j; capture `rd_data` into `box_a` (object i); go to CMP.
- CMP: the comparator sees `box_a` against live `rd_data` (object j).
  - Hit condition: overlap AND `en[i]` AND `en[j]`.
  - On hit: register i/j into `hit_a`/`hit_b`, OR bits i and j into `hit_mask`, go to EMIT.
  - Otherwise: advance.
- EMIT: `hit_valid`=1 and is held with stable indices until `hit_ready`. On the handshake cycle, advance.
- Advance:
  - If j<NUM_OBJ-1: j+=1, go to RD_B. `box_a` is reused, not refetched.
  - Else if i<NUM_OBJ-2: i+=1, j=i+2 (using the old i), go to RD_A.
  - Else go to DONE.
- DONE: `done`=1 for one cycle; go to IDLE.
- Overlap is strict on both axes: a.x1<b.x2 and a.x2>b.x1, and likewise for y. Comparisons are unsigned. Shared edges do not count as a hit.
- Disabled objects are still fetched and compared, but their results are forced to no-hit. Scan timing is therefore independent of `obj_enable`.
- `rd_addr` is 0 in IDLE, EMIT and DONE.

## Timing
- Reset values: `busy`, `done`, `hit_valid`, `hit_a`, `hit_b`, `hit_mask`, `rd_addr` are all 0; state is IDLE.
- Reset mid-scan aborts immediately. No event and no `done` are produced.
- `start` sampled at edge 0 puts RD_A in cycle 1.
- With no stalls, scan length is (NUM_OBJ-1) RD_A + NUM_OBJ(NUM_OBJ-1)/2 × (RD_B+CMP) = NUM_OBJ²-1 cycles, plus one cycle per EMIT handshake.
  - NUM_OBJ=8: 63 scan cycles; DONE in cycle 64.
- `busy`=1 in every non-IDLE state, DONE included. `done` coincides with the last `busy` cycle.
- `hit_mask` updates on the edge leaving CMP. It is final when `done` is high and holds until the next accepted `start`.
- A `start` arriving in the same cycle as DONE is ignored. `start` is accepted only in IDLE.
- The event interface is valid/ready:
  - `hit_valid` never drops without `hit_ready`.
  - With `hit_ready` tied high, each EMIT lasts exactly 1 cycle.

## Structure
- `collision_pkg` holds:
  - a `box_t` packed struct {y2,x2,y1,x1} with field offsets;
  - the `state_t` enum;
  - a `pair_event_t` struct {a,b}.
  - Both `rd_data` and `box_a` use `box_t`.
- One sub-module instance: `aabb_collision` (combinational comparator), fed from `box_a` and `rd_data`.
- The scheduler is the comparator's only user.

## Test plan
- NUM_OBJ=4, all boxes disjoint, `hit_ready`=1, start at edge 0 -> 15 `busy` scan cycles, then `done` in cycle 16. `hit_mask`=0000; `hit_valid` never asserted.
- NUM_OBJ=4, obj0 (0,0,10,10), obj2 (5,5,15,15), others at x≥100, disjoint -> one event a=0, b=2; `done` in cycle 17; `hit_mask`=0101.
- Touching edges: obj0 (0,0,10,10), obj1 (10,0,20,10) -> no event; `hit_mask`=0000.
- Previous overlap case with `hit_ready` low for 5 cycles in EMIT -> `hit_valid`, a=0, b=2 stable throughout; `rd_addr`=0; `done` delayed to cycle 22.
- Overlap case with `obj_enable`=1011 -> no event, `hit_mask`=0000, `done` in cycle 16. Then `start` pulsed mid-scan -> ignored.
- `rst` asserted in cycle 8 of a scan -> all outputs 0 asynchronously. A fresh `start` then completes a normal 15-cycle scan.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared types for the collision scheduler.
//   box_t        : packed bounding box {y2, x2, y1, x1}, x1 at the LSBs
//   *_LSB        : bit offsets of each box field inside a packed box word
//   state_t      : scheduler FSM states
//   pair_event_t : indices of an overlapping object pair {a, b}
//   axis_overlap : strict 1-D interval overlap helper
package collision_pkg;

    localparam int unsigned POS_MAX = 11;
    localparam int unsigned COORD_W = POS_MAX + 1;

    localparam int unsigned X1_LSB = 0;
    localparam int unsigned Y1_LSB = COORD_W;
    localparam int unsigned X2_LSB = 2 * COORD_W;
    localparam int unsigned Y2_LSB = 3 * COORD_W;

    // Event index width; sized for up to 8 objects.
    localparam int unsigned MAX_IDX_W = 3;

    typedef logic [POS_MAX:0] coord_t;

    typedef struct packed {
        coord_t y2;
        coord_t x2;
        coord_t y1;
        coord_t x1;
    } box_t;

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StRdB,
        StCmp,
        StEmit,
        StDone
    } state_t;

    typedef struct packed {
        logic [MAX_IDX_W-1:0] a;
        logic [MAX_IDX_W-1:0] b;
    } pair_event_t;

    // Strict overlap: shared edges are not an overlap.
    function automatic logic axis_overlap(coord_t a_lo, coord_t a_hi, coord_t b_lo, coord_t b_hi);
        return (a_lo < b_hi) && (a_hi > b_lo);
    endfunction

endpackage

// File: rtl/aabb_collision.sv
// Combinational axis-aligned bounding box overlap test (unsigned, strict).
//   box_a_i   : first box
//   box_b_i   : second box
//   overlap_o : 1 when the boxes overlap on both axes
module aabb_collision
    import collision_pkg::*;
(
    input  box_t box_a_i,
    input  box_t box_b_i,
    output logic overlap_o
);

    assign overlap_o = axis_overlap(box_a_i.x1, box_a_i.x2, box_b_i.x1, box_b_i.x2) &&
                       axis_overlap(box_a_i.y1, box_a_i.y2, box_b_i.y1, box_b_i.y2);

endmodule

// File: rtl/collision_scheduler.sv
// Walks every unordered object pair (i<j) once per scan, fetching boxes from the
// object attribute RAM (1-cycle read latency) and testing them with one shared
// AABB comparator. Overlapping enabled pairs are emitted on a valid/ready event
// port and accumulated into a per-object hit mask.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : begins a scan when idle
//   obj_enable   : per-object enable, captured when a scan starts
//   rd_addr      : RAM read address
//   rd_data      : box read at the previous cycle's address
//   hit_valid    : overlapping pair presented on hit_a/hit_b (hit_a < hit_b)
//   hit_ready    : consumer accepts the pair
//   hit_mask     : objects that hit anything during this scan
//   busy         : scan in progress
//   done         : one-cycle pulse at the end of a scan
module collision_scheduler
    import collision_pkg::*;
#(
    parameter int unsigned NUM_OBJ          = 8,
    parameter int unsigned POSITION_REG_MAX = 11,
    localparam int unsigned IDX_W           = $clog2(NUM_OBJ),
    localparam int unsigned BOX_W           = 4 * (POSITION_REG_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NUM_OBJ-1:0] obj_enable,
    output logic [IDX_W-1:0]   rd_addr,
    input  logic [BOX_W-1:0]   rd_data,
    output logic               hit_valid,
    output logic [IDX_W-1:0]   hit_a,
    output logic [IDX_W-1:0]   hit_b,
    input  logic               hit_ready,
    output logic [NUM_OBJ-1:0] hit_mask,
    output logic               busy,
    output logic               done
);

    localparam logic [IDX_W-1:0] LAST_J = IDX_W'(NUM_OBJ - 1);
    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(NUM_OBJ - 2);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     i_q, i_d;
    logic [IDX_W-1:0]     j_q, j_d;
    logic [NUM_OBJ-1:0]   en_q, en_d;
    logic [NUM_OBJ-1:0]   mask_q, mask_d;
    box_t                 box_a_q, box_a_d;
    logic                 load_a_q, load_a_d;
    pair_event_t          hit_q, hit_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 hit_valid_q, hit_valid_d;
    logic [IDX_W-1:0]     rd_addr_q, rd_addr_d;

    box_t                 rd_box;
    logic                 overlap;
    logic                 pair_hit;
    logic                 advance;

    always_comb begin
        rd_box.x1 = rd_data[X1_LSB +: COORD_W];
        rd_box.y1 = rd_data[Y1_LSB +: COORD_W];
        rd_box.x2 = rd_data[X2_LSB +: COORD_W];
        rd_box.y2 = rd_data[Y2_LSB +: COORD_W];
    end

    // In CMP, box_a_q holds object i and rd_data carries object j.
    aabb_collision u_aabb (
        .box_a_i   (box_a_q),
        .box_b_i   (rd_box),
        .overlap_o (overlap)
    );

    // Disabled objects are still compared so scan timing never depends on enables.
    assign pair_hit = overlap && en_q[i_q] && en_q[j_q];

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        en_d     = en_q;
        mask_d   = mask_q;
        box_a_d  = box_a_q;
        load_a_d = 1'b0;
        hit_d    = hit_q;
        advance  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    i_d     = '0;
                    j_d     = IDX_W'(1);
                    mask_d  = '0;
                    en_d    = obj_enable;
                    state_d = StRdA;
                end
            end
            StRdA: begin
                load_a_d = 1'b1;
                state_d  = StRdB;
            end
            StRdB: begin
                // Only the RD_B right after RD_A sees object i on rd_data; later
                // RD_B cycles in the same row reuse the stored box.
                if (load_a_q) begin
                    box_a_d = rd_box;
                end
                state_d = StCmp;
            end
            StCmp: begin
                if (pair_hit) begin
                    hit_d.a = MAX_IDX_W'(i_q);
                    hit_d.b = MAX_IDX_W'(j_q);
                    mask_d  = mask_q | (NUM_OBJ'(1) << i_q) | (NUM_OBJ'(1) << j_q);
                    state_d = StEmit;
                end else begin
                    advance = 1'b1;
                end
            end
            StEmit: begin
                if (hit_ready) begin
                    advance = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (advance) begin
            if (j_q < LAST_J) begin
                j_d     = j_q + IDX_W'(1);
                state_d = StRdB;
            end else if (i_q < LAST_I) begin
                i_d     = i_q + IDX_W'(1);
                j_d     = i_q + IDX_W'(2);
                state_d = StRdA;
            end else begin
                state_d = StDone;
            end
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);
        hit_valid_d = (state_d == StEmit);
        unique case (state_d)
            StRdA:        rd_addr_d = i_d;
            StRdB, StCmp: rd_addr_d = j_d;
            default:      rd_addr_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            i_q         <= '0;
            j_q         <= '0;
            en_q        <= '0;
            mask_q      <= '0;
            box_a_q     <= '0;
            load_a_q    <= 1'b0;
            hit_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hit_valid_q <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            en_q        <= en_d;
            mask_q      <= mask_d;
            box_a_q     <= box_a_d;
            load_a_q    <= load_a_d;
            hit_q       <= hit_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            hit_valid_q <= hit_valid_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign hit_valid = hit_valid_q;
    assign hit_a     = hit_q.a[IDX_W-1:0];
    assign hit_b     = hit_q.b[IDX_W-1:0];
    assign hit_mask  = mask_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed bench for collision_scheduler with four objects and a behavioural
// 1-cycle-latency object RAM.
module tb_collision_scheduler;

    localparam int unsigned N     = 4;
    localparam int unsigned IW    = 2;
    localparam int unsigned BW    = 48;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  obj_enable = '1;
    logic [IW-1:0] rd_addr;
    logic [BW-1:0] rd_data = '0;
    logic          hit_valid;
    logic [IW-1:0] hit_a;
    logic [IW-1:0] hit_b;
    logic          hit_ready = 1'b1;
    logic [N-1:0]  hit_mask;
    logic          busy;
    logic          done;

    logic [BW-1:0] ram [N];

    int checks = 0;
    int failures = 0;

    int  done_cyc, n_ev, ev_a, ev_b, busy_cnt, emit_len, addr1, addr2;
    bit  stable_ok;

    collision_scheduler #(
        .NUM_OBJ          (N),
        .POSITION_REG_MAX (11)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .obj_enable (obj_enable),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .hit_valid  (hit_valid),
        .hit_a      (hit_a),
        .hit_b      (hit_b),
        .hit_ready  (hit_ready),
        .hit_mask   (hit_mask),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        rd_data <= ram[rd_addr];
    end

    function automatic logic [BW-1:0] mk(int x1, int y1, int x2, int y2);
        logic [11:0] a, b, c, d;
        a = 12'(x1);
        b = 12'(y1);
        c = 12'(x2);
        d = 12'(y2);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_layout(input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                              input logic [BW-1:0] b2, input logic [BW-1:0] b3);
        ram[0] = b0;
        ram[1] = b1;
        ram[2] = b2;
        ram[3] = b3;
    endtask

    // Starts a scan at edge 0 and follows it cycle by cycle until done (bounded),
    // then steps one more cycle so the caller can look at the post-done state.
    task automatic run_scan(input int ready_low, input int poke_cyc,
                            output int d_cyc, output int nev, output int ea, output int eb,
                            output int bcnt, output int elen, output bit stab,
                            output int a1, output int a2);
        int  wait_n;
        bit  seen;
        d_cyc = -1; nev = 0; ea = -1; eb = -1; bcnt = 0; elen = 0; stab = 1'b1;
        a1 = -1; a2 = -1; seen = 1'b0; wait_n = 0;
        hit_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (busy) bcnt++;
            if (cyc == 1) a1 = int'(rd_addr);
            if (cyc == 2) a2 = int'(rd_addr);
            start = (cyc == poke_cyc);
            if (hit_valid) begin
                elen++;
                if (!seen) begin
                    ea = int'(hit_a);
                    eb = int'(hit_b);
                    seen = 1'b1;
                    wait_n = 0;
                end else if (int'(hit_a) != ea || int'(hit_b) != eb) begin
                    stab = 1'b0;
                end
                if (rd_addr !== '0) stab = 1'b0;
                hit_ready = (wait_n >= ready_low);
                wait_n++;
                if (hit_ready) begin
                    nev++;
                    seen = 1'b0;
                end
            end else begin
                hit_ready = 1'b1;
            end
            if (done) begin
                d_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        hit_ready = 1'b1;
    endtask

    initial begin
        set_layout(mk(0, 0, 10, 10), mk(20, 0, 30, 10), mk(40, 0, 50, 10), mk(60, 0, 70, 10));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hit_valid", hit_valid, 0);
        chk("rst_hit_a", hit_a, 0);
        chk("rst_hit_b", hit_b, 0);
        chk("rst_hit_mask", hit_mask, 0);
        chk("rst_rd_addr", rd_addr, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // All disjoint
        run_scan(0, 0, done_cyc, n_ev, ev_a, ev_b, busy_cnt, emit_len, stable_ok, addr1, addr2);
        chk("disj_done_cycle", done_cyc, 16);
        chk("disj_busy_cycles", busy_cnt, 16);
        chk("disj_events", n_ev, 0);
        chk("disj_emit_cycles", emit_len, 0);
        chk("disj_mask", hit_mask, 4'b0000);
        chk("disj_addr_c1", addr1, 0);
        chk("disj_addr_c2", addr2, 1);
        chk("disj_post_busy", busy, 0);
        chk("disj_post_done", done, 0);

        // obj0 overlaps obj2
        set_layout(mk(0, 0, 10, 10), mk(100, 0, 110, 10), mk(5, 5, 15, 15), mk(200, 0, 210, 10));
        run_scan(0, 0, done_cyc, n_ev, ev_a, ev_b, busy_cnt, emit_len, stable_ok, addr1, addr2);
        chk("ov02_done_cycle", done_cyc, 17);
        chk("ov02_events", n_ev, 1);
        chk("ov02_a", ev_a, 0);
        chk("ov02_b", ev_b, 2);
        chk("ov02_emit_cycles", emit_len, 1);
        chk("ov02_mask", hit_mask, 4'b0101);

        // obj1 overlaps obj3 (second row, reused box_a)
        set_layout(mk(0, 0, 10, 10), mk(100, 0, 110, 10), mk(300, 0, 310, 10),
                   mk(105, 5, 120, 20));
        run_scan(0, 0, done_cyc, n_ev, ev_a, ev_b, busy_cnt, emit_len, stable_ok, addr1, addr2);
        chk("ov13_done_cycle", done_cyc, 17);
        chk("ov13_a", ev_a, 1);
        chk("ov13_b", ev_b, 3);
        chk("ov13_mask", hit_mask, 4'b1010);

        // Touching edges only; start pulsed during DONE must be ignored
        set_layout(mk(0, 0, 10, 10), mk(10, 0, 20, 10), mk(100, 0, 110, 10), mk(200, 0, 210, 10));
        run_scan(0, 16, done_cyc, n_ev, ev_a, ev_b, busy_cnt, emit_len, stable_ok, addr1, addr2);
        chk("touch_done_cycle", done_cyc, 16);
        chk("touch_events", n_ev, 0);
        chk("touch_mask", hit_mask, 4'b0000);
        chk("start_in_done_busy", busy, 0);

        // Back-pressure: ready low for 5 EMIT cycles
        set_layout(mk(0, 0, 10, 10), mk(100, 0, 110, 10), mk(5, 5, 15, 15), mk(200, 0, 210, 10));
        run_scan(5, 0, done_cyc, n_ev, ev_a, ev_b, busy_cnt, emit_len, stable_ok, addr1, addr2);
        chk("stall_done_cycle", done_cyc, 22);
        chk("stall_emit_cycles", emit_len, 6);
        chk("stall_stable_and_addr0", stable_ok, 1);
        chk("stall_events", n_ev, 1);
        chk("stall_a", ev_a, 0);
        chk("stall_b", ev_b, 2);
        chk("stall_mask", hit_mask, 4'b0101);

        // obj2 disabled; start pulsed mid-scan
        obj_enable = 4'b1011;
        run_scan(0, 5, done_cyc, n_ev, ev_a, ev_b, busy_cnt, emit_len, stable_ok, addr1, addr2);
        chk("en_done_cycle", done_cyc, 16);
        chk("en_events", n_ev, 0);
        chk("en_mask", hit_mask, 4'b0000);
        chk("en_busy_cycles", busy_cnt, 16);
        obj_enable = 4'b1111;

        // Reset in cycle 8 of an overlapping scan
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_mask", hit_mask, 4'b0101);
        chk("pre_rst_rd_addr", rd_addr, 3);
        rst = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_hit_valid", hit_valid, 0);
        chk("async_rst_hit_a", hit_a, 0);
        chk("async_rst_hit_b", hit_b, 0);
        chk("async_rst_mask", hit_mask, 0);
        chk("async_rst_rd_addr", rd_addr, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fresh scan after reset
        set_layout(mk(0, 0, 10, 10), mk(20, 0, 30, 10), mk(40, 0, 50, 10), mk(60, 0, 70, 10));
        run_scan(0, 0, done_cyc, n_ev, ev_a, ev_b, busy_cnt, emit_len, stable_ok, addr1, addr2);
        chk("after_rst_done_cycle", done_cyc, 16);
        chk("after_rst_events", n_ev, 0);
        chk("after_rst_mask", hit_mask, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
